// File: rtl/port_array_serializer_pkg.sv
// Shared types for the array-to-element serializer.
package port_array_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index width; a single-element array still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/port_array_serializer_idx.sv
// Element index for the serializer: clear on load, step on output beats,
// and flag the final element of the array.
module serializer_idx_counter
  import port_array_serializer_pkg::*;
#(
  parameter int nports = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        incr,
  output logic [idx_w(nports)-1:0]    idx,
  output logic                        last
);

  localparam int iw = idx_w(nports);

  assign last = (idx == iw'(nports - 1));

  // Clear beats incr so a back-to-back load restarts at element 0.
  always_ff @(posedge clk) begin
    if (reset || clear)
      idx <= '0;
    else if (incr && !last)
      idx <= idx + iw'(1);
  end

endmodule

// File: rtl/port_array_serializer.sv
// Accepts an nports-wide array in one handshake and replays its elements
// one per cycle, with a back-to-back load allowed on the last beat.
module port_array_serializer
  import port_array_serializer_pkg::*;
#(
  parameter int nports = 2,
  parameter int nbits  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [nbits-1:0] istream_msg [nports],
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] ostream_msg
);

  localparam int iw = idx_w(nports);

  state_t           state, state_nxt;
  logic [iw-1:0]    idx;
  logic             last;
  logic             in_xfer, out_xfer;
  logic [nbits-1:0] buf_r [nports];

  assign in_xfer  = istream_val & istream_rdy;
  assign out_xfer = ostream_val & ostream_rdy;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_xfer) state_nxt = SEND;
      SEND:    if (out_xfer && last && !in_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs fall back to IDLE values while reset is held.
  always_comb begin
    istream_rdy = 1'b1;
    ostream_val = 1'b0;
    if (!reset && state == SEND) begin
      ostream_val = 1'b1;
      istream_rdy = last & ostream_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer)
      buf_r <= istream_msg;
  end

  serializer_idx_counter #(.nports(nports)) u_idx (
    .clk   (clk),
    .reset (reset),
    .clear (in_xfer),
    .incr  (out_xfer),
    .idx   (idx),
    .last  (last)
  );

  generate
    if (nports == 1) begin : g_one
      assign ostream_msg = buf_r[0];
    end else begin : g_many
      assign ostream_msg = buf_r[idx];
    end
  endgenerate

endmodule

// File: tb/tb_port_array_serializer.sv
// Serializer bench: one DUT per array size, a queue model of pending
// elements, directed cases followed by randomized handshakes.
module tb_port_array_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v, r;
  int          sel;
  logic [31:0] src [4];

  logic [3:0]  ival, ordy;
  logic [31:0] m1 [1];
  logic [31:0] m2 [2];
  logic [31:0] m3 [3];
  logic [31:0] m4 [4];
  logic        irdy1, irdy2, irdy3, irdy4;
  logic        oval1, oval2, oval3, oval4;
  logic [31:0] omsg1, omsg2, omsg3, omsg4;
  logic        irdy_s, oval_s;
  logic [31:0] omsg_s;

  always_comb begin
    ival = '0;
    ordy = '0;
    for (int k = 0; k < 4; k++) begin
      ival[k] = v && (sel == k);
      ordy[k] = r && (sel == k);
    end
    m1[0] = src[0];
    for (int i = 0; i < 2; i++) m2[i] = src[i];
    for (int i = 0; i < 3; i++) m3[i] = src[i];
    for (int i = 0; i < 4; i++) m4[i] = src[i];
  end

  always_comb begin
    irdy_s = irdy1; oval_s = oval1; omsg_s = omsg1;
    case (sel)
      1: begin irdy_s = irdy2; oval_s = oval2; omsg_s = omsg2; end
      2: begin irdy_s = irdy3; oval_s = oval3; omsg_s = omsg3; end
      3: begin irdy_s = irdy4; oval_s = oval4; omsg_s = omsg4; end
      default: ;
    endcase
  end

  port_array_serializer #(.nports(1), .nbits(32)) u1 (
    .clk(clk), .reset(reset), .istream_val(ival[0]), .istream_rdy(irdy1),
    .istream_msg(m1), .ostream_val(oval1), .ostream_rdy(ordy[0]), .ostream_msg(omsg1));
  port_array_serializer #(.nports(2), .nbits(32)) u2 (
    .clk(clk), .reset(reset), .istream_val(ival[1]), .istream_rdy(irdy2),
    .istream_msg(m2), .ostream_val(oval2), .ostream_rdy(ordy[1]), .ostream_msg(omsg2));
  port_array_serializer #(.nports(3), .nbits(32)) u3 (
    .clk(clk), .reset(reset), .istream_val(ival[2]), .istream_rdy(irdy3),
    .istream_msg(m3), .ostream_val(oval3), .ostream_rdy(ordy[2]), .ostream_msg(omsg3));
  port_array_serializer #(.nports(4), .nbits(32)) u4 (
    .clk(clk), .reset(reset), .istream_val(ival[3]), .istream_rdy(irdy4),
    .istream_msg(m4), .ostream_val(oval4), .ostream_rdy(ordy[3]), .ostream_msg(omsg4));

  // Elements still owed by the selected DUT, in emission order.
  logic [31:0] q [$];
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model mid-cycle, then advance one clock.
  task automatic step(input string tag);
    logic eo, er;
    bit   ix, ox;
    #1;
    eo = !reset && (q.size() > 0);
    er = reset || (q.size() == 0) || (q.size() == 1 && r);
    chk({tag, "_val"}, 32'(oval_s), 32'(eo));
    chk({tag, "_rdy"}, 32'(irdy_s), 32'(er));
    if (eo) chk({tag, "_msg"}, omsg_s, q[0]);
    ix = v && er && !reset;
    ox = eo && r;
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (ox) void'(q.pop_front());
      if (ix) for (int i = 0; i <= sel; i++) q.push_back(src[i]);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; v = 1'b0; r = 1'b0; sel = 1;
    for (int i = 0; i < 4; i++) src[i] = '0;
    step("rst0");
    step("rst1");
    reset = 1'b0;
    step("post_rst");

    // basic nports=2
    src[0] = 32'hAAAA0000; src[1] = 32'hBBBB1111; v = 1'b1; r = 1'b1;
    step("basic_in");
    v = 1'b0;
    #1 chk("basic_b0", omsg_s, 32'hAAAA0000);
    step("basic_b0");
    #1 chk("basic_b1", omsg_s, 32'hBBBB1111);
    step("basic_b1");
    step("basic_idle");

    // back-to-back arrays
    src[0] = 1; src[1] = 2; v = 1'b1;
    step("b2b_in");
    src[0] = 3; src[1] = 4;
    #1 chk("b2b_e1", omsg_s, 1);
    step("b2b_e1");
    #1 chk("b2b_rdy_on_2", 32'(irdy_s), 1);
    chk("b2b_e2", omsg_s, 2);
    step("b2b_e2");
    v = 1'b0;
    #1 chk("b2b_e3", omsg_s, 3);
    step("b2b_e3");
    #1 chk("b2b_e4", omsg_s, 4);
    step("b2b_e4");
    step("b2b_idle");

    // backpressure on the last element
    src[0] = 1; src[1] = 2; v = 1'b1;
    step("bp_in");
    v = 1'b0;
    step("bp_e1");
    r = 1'b0;
    repeat (3) begin
      #1 chk("bp_msg", omsg_s, 2);
      chk("bp_val", 32'(oval_s), 1);
      chk("bp_rdy", 32'(irdy_s), 0);
      step("bp_hold");
    end
    r = 1'b1;
    #1 chk("bp_last_rdy", 32'(irdy_s), 1);
    step("bp_e2");
    step("bp_idle");

    // nports=1
    sel = 0; src[0] = 32'hDEADBEEF; v = 1'b1;
    step("n1_in");
    src[0] = 32'h12345678;
    #1 chk("n1_b0", omsg_s, 32'hDEADBEEF);
    chk("n1_rdy", 32'(irdy_s), 1);
    step("n1_b0");
    r = 1'b0;
    #1 chk("n1_rdy_track", 32'(irdy_s), 0);
    chk("n1_b1", omsg_s, 32'h12345678);
    step("n1_stall");
    r = 1'b1; v = 1'b0;
    step("n1_b1");
    step("n1_idle");

    // reset mid-array, nports=4
    sel = 3; src[0] = 5; src[1] = 6; src[2] = 7; src[3] = 8; v = 1'b1;
    step("rm_in");
    v = 1'b0;
    step("rm_e5");
    step("rm_e6");
    reset = 1'b1;
    step("rm_reset");
    reset = 1'b0;
    src[0] = 9; src[1] = 10; src[2] = 11; src[3] = 12; v = 1'b1;
    step("rm_new_in");
    v = 1'b0;
    #1 chk("rm_first_after", omsg_s, 9);
    repeat (5) step("rm_drain");

    // randomized handshakes across array sizes
    foreach (m4[n]) begin
      if (n == 1) continue;
      sel = n;
      repeat (300) begin
        v = 1'($urandom_range(0, 1));
        r = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) src[i] = $urandom;
        step("rnd");
      end
      v = 1'b0; r = 1'b1;
      repeat (6) step("rnd_drain");
      chk("rnd_empty", 32'(q.size()), 0);
    end

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule

// File: doc/port_array_serializer.md
PORT_ARRAY_SERIALIZER -- requirements
Module: port_array_serializer

Interface
REQ-001 SHALL have parameter nports, default 2: number of elements in one input array message; legal range is 1 or more.
REQ-002 SHALL have parameter nbits, default 32: width of each element.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port istream_val  input  1: an input array message is valid.
REQ-006 SHALL have port istream_rdy  output  1: the block can accept an input array message.
REQ-007 SHALL have port istream_msg  input  nbits x unpacked [nports]: the array message, with element i on index i.
REQ-008 SHALL have port ostream_val  output  1: an output element is valid.
REQ-009 SHALL have port ostream_rdy  input  1: the consumer accepts the output element.
REQ-010 SHALL have port ostream_msg  output  nbits: the current output element.

Function
REQ-011 SHALL transfer on a stream in any cycle where val and rdy are both 1 at the rising clock edge; SHALL do nothing otherwise.
REQ-012 SHALL use a two-state machine: IDLE and SEND.
REQ-013 In IDLE, SHALL drive istream_rdy=1 and ostream_val=0; on an input transfer, SHALL capture all nports elements into an internal buffer, set idx=0, and go to SEND.
REQ-014 In SEND, SHALL drive ostream_val=1 and ostream_msg=buf[idx]; buf and idx SHALL hold stable while ostream_rdy=0.
REQ-015 In SEND, on an output transfer with idx<nports-1, SHALL increment idx and stay in SEND.
REQ-016 In SEND, on an output transfer with idx==nports-1 (last beat), SHALL go to IDLE, unless an input transfer happens in the same cycle.
REQ-017 SHALL drive istream_rdy = ostream_rdy during the SEND last beat, so a new array can be accepted back-to-back; this is the only combinational rdy->rdy path.
REQ-018 On a last-beat output transfer and a simultaneous input transfer, SHALL capture the new array, set idx=0, and stay in SEND.
REQ-019 SHALL drive istream_rdy=0 in SEND on every beat except the last.
REQ-020 SHALL have a latency of one cycle from an input transfer to the first ostream_val; sustained throughput SHALL be one element per cycle.
REQ-021 SHALL make idx max(1, clog2(nports)) bits wide; idx SHALL never exceed nports-1 and SHALL never wrap past it.
REQ-022 With nports=1, every SEND beat SHALL be a last beat.
REQ-023 SHALL emit elements in index order 0..nports-1 and SHALL never drop or duplicate an element.

Reset
REQ-024 While reset=1 at a rising edge, SHALL set state=IDLE and idx=0; buf contents are don't-care.
REQ-025 During and immediately after reset, SHALL drive ostream_val=0 and istream_rdy=1 (IDLE outputs).
REQ-026 Reset asserted mid-SEND SHALL abandon the array in progress; no further elements of it SHALL appear.

Structure
REQ-027 SHALL place the state enum (IDLE, SEND) in the shared package port_array_serializer_pkg.
REQ-028 SHALL implement idx as one sub-module, serializer_idx_counter, with clear, increment, and last-beat flag, parameterized by nports.
REQ-029 SHALL implement the buffer as a register array with a load enable; no memory macro.

Verification
REQ-030 Basic, nports=2, nbits=32: input {0xAAAA0000, 0xBBBB1111} with ostream_rdy=1 -> outputs 0xAAAA0000 then 0xBBBB1111 on consecutive cycles, starting one cycle after the input transfer.
REQ-031 Back-to-back: two arrays {1,2} and {3,4} with istream_val held high and ostream_rdy=1 -> outputs 1,2,3,4 with no bubble; istream_rdy=1 on the cycle emitting 2.
REQ-032 Backpressure: ostream_rdy=0 for 3 cycles mid-array -> ostream_msg stays 2 and ostream_val stays 1; istream_rdy stays 0 until the last beat.
REQ-033 nports=1: input 0xDEADBEEF, then 0x12345678 back-to-back -> one output per cycle; istream_rdy tracks ostream_rdy while in SEND.
REQ-034 Reset mid-array: nports=4, array {5,6,7,8}, reset asserted after 6 is output -> next outputs are only from arrays accepted after reset; 7 and 8 never appear.
REQ-035 Random: random val/rdy toggling, nports in {1,3,4} -> output sequence equals the concatenation of the accepted arrays, checked against a scoreboard.
